// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters over a single response channel.
// Build option ALU_ARB_FIXED_PRIO_EN: lowest-index requester always wins (no round-robin pointer).
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0010;
    localparam logic [3:0] OpOr    = 4'b0011;
    localparam logic [3:0] OpXor   = 4'b0100;
    localparam logic [3:0] OpLui   = 4'b0111;
    localparam logic [3:0] OpAuipc = 4'b1000;

    state_e         state_q, state_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [3:0]     op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    res_q, res_d;
    logic           zero_q, zero_d;
    logic           valid_q, valid_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [31:0]    sel_a, sel_b;
    logic [3:0]     sel_op;
    logic [31:0]    alu_result;
    logic           alu_zero;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Lowest valid index overall, overridden by the lowest valid index at or above rr_ptr.
    always_comb begin
        gnt_found = |req_valid;
        gnt_idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) gnt_idx = IDW'(i);
        end
`ifndef ALU_ARB_FIXED_PRIO_EN
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= rr_ptr_q)) gnt_idx = IDW'(i);
        end
`endif
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[4*i +: 4];
            end
        end
    end

    always_comb begin
        case (op_q)
            OpAdd:   alu_result = a_q + b_q;
            OpSub:   alu_result = a_q - b_q;
            OpAnd:   alu_result = a_q & b_q;
            OpOr:    alu_result = a_q | b_q;
            OpXor:   alu_result = a_q ^ b_q;
            OpLui:   alu_result = b_q;
            OpAuipc: alu_result = a_q + b_q;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == StIdle) && gnt_found) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                req_ready[i] = (gnt_idx == IDW'(i));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = gnt_idx;
                    state_d = StExec;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (int'(gnt_idx) == int'(NREQ) - 1) ? '0 : gnt_idx + 1'b1;
`endif
                end
            end
            StExec: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus hand sequences; responses checked against a scoreboard queue.
module tb_alu_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;
    localparam int NVEC = 11;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*4-1:0]    req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;

    typedef struct {
        int unsigned r;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    res;
        logic           zero;
        int             cyc;
        bit             lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[NVEC];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d result %h, expected no response",
                         rsp_id, rsp_result);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_result", rsp_result, mon_e.res);
                check("rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
                if (mon_e.lat) check("latency", 32'(cyc - mon_e.cyc), 32'd2);
            end
        end
    end

    task automatic issue(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] res, input logic zero,
                         input bit push, input bit lat);
        exp_t e;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        @(posedge clk);
        #1;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_op = 8'($urandom);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_op[4*r +: 4] = op;
        req_valid = oh;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(oh));
        if (push) begin
            e.id = IDW'(r);
            e.res = res;
            e.zero = zero;
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t ce;
        logic [NREQ-1:0] oh;
        int exp_id;
        int n;

        vecs[0]  = '{0, 32'd5,        32'd3,        4'b0001, 32'd2,        1'b0};
        vecs[1]  = '{1, 32'hFFFFFFFF, 32'd1,        4'b0000, 32'd0,        1'b1};
        vecs[2]  = '{0, 32'hF0F000FF, 32'h0FF00F0F, 4'b0010, 32'h00F0000F, 1'b0};
        vecs[3]  = '{1, 32'h00001200, 32'h00000034, 4'b0011, 32'h00001234, 1'b0};
        vecs[4]  = '{0, 32'hAAAA5555, 32'hAAAA5555, 4'b0100, 32'd0,        1'b1};
        vecs[5]  = '{1, 32'd7,        32'h12345000, 4'b0111, 32'h12345000, 1'b0};
        vecs[6]  = '{0, 32'h00001000, 32'h00000234, 4'b1000, 32'h00001234, 1'b0};
        vecs[7]  = '{1, 32'd3,        32'd4,        4'b1111, 32'd0,        1'b1};
        vecs[8]  = '{0, 32'd0,        32'd1,        4'b0001, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{1, 32'd1,        32'd1,        4'b0101, 32'd0,        1'b1};
        vecs[10] = '{0, 32'h7FFFFFFF, 32'd1,        4'b0000, 32'h80000000, 1'b0};

        // Reset state, with requests present so req_ready must still be held low.
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zero, 1'b1,
                  1'b1);
            drain();
        end

        // Backpressure: response held, a new request waits behind it.
        rsp_ready = 1'b0;
        issue(0, 32'd100, 32'd58, 4'b0001, 32'd42, 1'b0, 1'b1, 1'b0);
        req_a[63:32] = 32'h00000001;
        req_b[63:32] = 32'h00000002;
        req_op[7:4] = 4'b0011;
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_rsp_result", rsp_result, 32'd42);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'd2);
        ce = '{1'b1, 32'd3, 1'b0, cyc, 1'b1};
        sb.push_back(ce);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Reset during EXEC: the operation is discarded and no response appears.
        issue(0, 32'd7, 32'd7, 4'b0100, 32'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        check("midrst_rsp_result", rsp_result, 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Contention: both requesters held valid; rr_ptr starts from 0 after reset.
        @(posedge clk);
        #1;
        req_a = {32'd20, 32'd10};
        req_b = {32'd1, 32'd1};
        req_op = 8'h00;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == '0 && n < 10);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % 2;
`endif
            oh = '0;
            oh[exp_id] = 1'b1;
            check("contend_req_ready", 32'(req_ready), 32'(oh));
            ce = '{IDW'(exp_id), (exp_id == 1) ? 32'd21 : 32'd11, 1'b0, cyc, 1'b1};
            sb.push_back(ce);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
